// File: rtl/register_load_arbiter_pkg.sv
// Shared types and defaults for the register load arbiter.
// State encoding, default parameters and burst counter width.
package register_load_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_BURST = 4;
  localparam int CNT_W         = 4;

endpackage

// File: rtl/register_load_arbiter_reg.sv
// 8-bit falling-edge register with active-low load enable.
// Ports: Clk, in, Enbar (0 = load), out. No reset.
module neg_reg #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic [WIDTH-1:0] in,
  input  logic             Enbar,
  output logic [WIDTH-1:0] out
);

  always_ff @(negedge Clk) begin
    if (!Enbar) out <= in;
  end

endmodule

// File: rtl/register_load_arbiter_rr_pick.sv
// Round-robin picker: first set req at or after ptr, wrapping,
// optionally skipping excl_id. Outputs any and win_id.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            excl_en,
  input  logic [ID_W-1:0] excl_id,
  output logic            any,
  output logic [ID_W-1:0] win_id
);

  logic [ID_W-1:0] idx;

  always_comb begin
    any    = 1'b0;
    win_id = '0;
    idx    = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && req[idx] &&
          !(excl_en && idx == excl_id)) begin
        any    = 1'b1;
        win_id = idx;
      end
      idx = (idx == ID_W'(NREQ - 1)) ?
            '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/register_load_arbiter.sv
// Round-robin arbiter sharing one negedge register among NREQ requesters.
// Ports: Clk, Rst(n), req, lock, data -> reg_in, reg_enbar, gnt, gnt_id, busy.
module register_load_arbiter
  import register_load_arbiter_pkg::*;
#(
  parameter  int NREQ      = DEF_NREQ,
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int MAX_BURST = DEF_MAX_BURST,
  localparam int ID_W      = $clog2(NREQ)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [WIDTH-1:0]      reg_in,
  output logic                  reg_enbar,
  output logic [NREQ-1:0]       gnt,
  output logic [ID_W-1:0]       gnt_id,
  output logic                  busy
);

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  pnext;
  logic [ID_W-1:0]  pick_ptr;
  logic [CNT_W-1:0] burst_cnt;
  logic             any;
  logic [ID_W-1:0]  win_id;
  logic             hold;
  logic [WIDTH-1:0] words [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_w
    assign words[i] = data[i*WIDTH +: WIDTH];
  end

  assign pnext = (gnt_id == ID_W'(NREQ - 1)) ?
                 '0 : gnt_id + 1'b1;

  // At LOAD exit the search restarts just past the
  // current winner and skips it.
  assign pick_ptr = busy ? pnext : ptr;

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req     (req),
    .ptr     (pick_ptr),
    .excl_en (busy),
    .excl_id (gnt_id),
    .any     (any),
    .win_id  (win_id)
  );

  assign hold = req[gnt_id] && lock[gnt_id] &&
                (burst_cnt < CNT_W'(MAX_BURST));

  assign busy      = (state == LOAD);
  assign reg_enbar = ~busy;

  always_comb begin
    gnt = '0;
    if (busy) gnt[gnt_id] = 1'b1;
  end

  always_ff @(negedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_id    <= '0;
      burst_cnt <= '0;
      reg_in    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            state     <= LOAD;
            gnt_id    <= win_id;
            reg_in    <= words[win_id];
            burst_cnt <= CNT_W'(1);
          end
        end
        LOAD: begin
          if (hold) begin
            reg_in    <= words[gnt_id];
            burst_cnt <= burst_cnt + 1'b1;
          end else begin
            ptr <= pnext;
            if (any) begin
              gnt_id    <= win_id;
              reg_in    <= words[win_id];
              burst_cnt <= CNT_W'(1);
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_load_arbiter.sv
// Bench: register_load_arbiter plus neg_reg, directed cases and
// random traffic checked against a behavioural model.
module tb_register_load_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int MB   = 4;

  logic            Clk;
  logic            Rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] lock;
  logic [NREQ*W-1:0] data;
  logic [W-1:0]    reg_in;
  logic            reg_enbar;
  logic [NREQ-1:0] gnt;
  logic [1:0]      gnt_id;
  logic            busy;
  logic [W-1:0]    q;

  int vectors = 0;
  int errs    = 0;

  register_load_arbiter #(
    .NREQ      (NREQ),
    .WIDTH     (W),
    .MAX_BURST (MB)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .req       (req),
    .lock      (lock),
    .data      (data),
    .reg_in    (reg_in),
    .reg_enbar (reg_enbar),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  neg_reg #(.WIDTH(W)) u_reg (
    .Clk   (Clk),
    .in    (reg_in),
    .Enbar (reg_enbar),
    .out   (q)
  );

  initial Clk = 1'b1;
  always #5 Clk = ~Clk;

  // ---------------- behavioural model ----------------
  logic         m_busy;
  int           m_w;
  int           m_ptr;
  int           m_cnt;
  logic [W-1:0] m_regin;
  logic [W-1:0] m_q;
  logic         m_qv = 1'b0;

  function automatic logic [W-1:0] word(input int i);
    return data[i*W +: W];
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r,
                              input int start,
                              input int excl);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (start + k) % NREQ;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  always @(negedge Clk or negedge Rst) begin
    int nxt;
    if (!Rst) begin
      m_busy  = 1'b0;
      m_w     = 0;
      m_ptr   = 0;
      m_cnt   = 0;
      m_regin = '0;
    end else begin
      if (m_busy) begin
        m_q  = m_regin;
        m_qv = 1'b1;
      end
      if (!m_busy) begin
        nxt = pick(req, m_ptr, -1);
        if (nxt >= 0) begin
          m_busy  = 1'b1;
          m_w     = nxt;
          m_cnt   = 1;
          m_regin = word(nxt);
        end
      end else if (req[m_w] && lock[m_w] && m_cnt < MB) begin
        m_cnt   = m_cnt + 1;
        m_regin = word(m_w);
      end else begin
        m_ptr = (m_w + 1) % NREQ;
        nxt   = pick(req, m_ptr, m_w);
        if (nxt >= 0) begin
          m_w     = nxt;
          m_cnt   = 1;
          m_regin = word(nxt);
        end else begin
          m_busy = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // compare process: outputs are stable mid-cycle
  always @(posedge Clk) begin
    logic [NREQ-1:0] eg;
    eg = m_busy ? NREQ'(1 << m_w) : '0;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("enbar", 32'(reg_enbar), 32'(!m_busy));
    chk("gnt", 32'(gnt), 32'(eg));
    chk("reg_in", 32'(reg_in), 32'(m_regin));
    if (m_busy) chk("gnt_id", 32'(gnt_id), 32'(m_w));
    if (m_qv) chk("reg_q", 32'(q), 32'(m_q));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic setw(input int i, input logic [W-1:0] v);
    data[i*W +: W] = v;
  endtask

  task automatic rst_pulse();
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    tick();
  endtask

  logic [NREQ-1:0] seq [6];
  logic [NREQ-1:0] exp3 [5];
  logic [NREQ-1:0] exp4 [6];

  initial begin
    exp3 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp4 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
             4'b0010, 4'b0001};
    Rst  = 1'b0;
    req  = '0;
    lock = '0;
    data = '0;
    tick();
    tick();
    chk("rst_enbar", 32'(reg_enbar), 32'd1);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_reg_in", 32'(reg_in), 32'd0);
    chk("rst_gnt_id", 32'(gnt_id), 32'd0);
    Rst = 1'b1;
    tick();

    // single request
    setw(0, 8'hA5);
    req = 4'b0001;
    tick();
    chk("single_gnt", 32'(gnt), 32'b0001);
    chk("single_enbar", 32'(reg_enbar), 32'd0);
    chk("single_in", 32'(reg_in), 32'hA5);
    req = '0;
    tick();
    chk("single_q", 32'(q), 32'hA5);
    chk("single_idle", 32'(busy), 32'd0);

    // data change during LOAD is ignored
    setw(0, 8'h3C);
    req = 4'b0001;
    tick();
    chk("stab_gnt", 32'(gnt), 32'b0001);
    setw(0, 8'hFF);
    req = '0;
    tick();
    chk("stab_q", 32'(q), 32'h3C);

    // async reset in the middle of a LOAD
    setw(1, 8'h77);
    req = 4'b0010;
    tick();
    chk("pre_rst_gnt", 32'(gnt), 32'b0010);
    #2;
    Rst = 1'b0;
    #1;
    chk("mid_rst_enbar", 32'(reg_enbar), 32'd1);
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    req = '0;
    tick();
    chk("mid_rst_q", 32'(q), 32'h3C);
    Rst = 1'b1;
    tick();

    // round robin with all requesting
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rr%0d", i), 32'(gnt), 32'(exp3[i]));
    end
    req = '0;
    tick();
    tick();

    // burst lock with cap
    rst_pulse();
    setw(0, 8'h01);
    setw(1, 8'h55);
    req  = 4'b0011;
    lock = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      tick();
      seq[i] = gnt;
      if (i < 3) setw(0, W'(i + 2));
      if (i == 4) chk("burst_q", 32'(q), 32'h04);
    end
    for (int i = 0; i < 6; i++)
      chk($sformatf("burst%0d", i), 32'(seq[i]), 32'(exp4[i]));
    req  = '0;
    lock = '0;
    tick();
    tick();

    // contention after wrap (ptr = 3)
    rst_pulse();
    setw(2, 8'h22);
    req = 4'b0100;
    tick();
    chk("wrap_pre", 32'(gnt), 32'b0100);
    req = '0;
    tick();
    setw(0, 8'h11);
    setw(3, 8'h33);
    req = 4'b1001;
    tick();
    chk("wrap_g3", 32'(gnt), 32'b1000);
    req = 4'b0001;
    tick();
    chk("wrap_g0", 32'(gnt), 32'b0001);
    req = '0;
    tick();
    chk("wrap_q", 32'(q), 32'h11);
    chk("wrap_idle", 32'(busy), 32'd0);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      req  = NREQ'($urandom);
      if ($urandom_range(0, 3) == 0) req = '0;
      lock = NREQ'($urandom) & NREQ'($urandom);
      data = ($urandom_range(0, 1) == 0) ? data :
             (NREQ*W)'($urandom);
      if (n % 700 == 350) begin
        #2;
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
      end
      tick();
    end
    req  = '0;
    lock = '0;
    tick();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
